// File: rtl/sync_fifo_read_port.sv
// sync_fifo_read_port: FIFO read side with a registered output stage; defining SYNC_FIFO_READ_PORT_COUNT_EN adds a word count output.
module sync_fifo_read_port #(
  parameter int depth     = 4,
  parameter int ptr_width = $clog2(depth) + 1,
  parameter int bit_width = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ptr_width-1:0] w_ptr,
  output logic [ptr_width-1:0] r_ptr,
  output logic [ptr_width-2:0] raddr,
  input  logic [bit_width-1:0] rdata,
  input  logic                 flush,
  output logic                 deq_val,
  input  logic                 deq_rdy,
  output logic [bit_width-1:0] deq_msg,
  output logic                 empty
`ifdef SYNC_FIFO_READ_PORT_COUNT_EN
  ,
  output logic [ptr_width-1:0] count
`endif
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t r_state;
  logic   w_load;
  assign empty   = r_ptr == w_ptr;
  assign raddr   = r_ptr[ptr_width-2:0];
  assign deq_val = r_state == HOLD;
  assign w_load  = ~empty & (~deq_val | deq_rdy) & ~flush;
`ifdef SYNC_FIFO_READ_PORT_COUNT_EN
  assign count = (w_ptr - r_ptr) + ptr_width'(deq_val);
`endif
  // reset beats flush, flush beats load/accept
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_state <= IDLE;
      deq_msg <= '0;
    end else if (flush) begin
      r_ptr   <= w_ptr;
      r_state <= IDLE;
    end else if (w_load) begin
      deq_msg <= rdata;
      r_ptr   <= r_ptr + 1'b1;
      r_state <= HOLD;
    end else if (deq_rdy) begin
      r_state <= IDLE;
    end
  end
endmodule

// File: tb/tb_sync_fifo_read_port.sv
// tb_sync_fifo_read_port: scoreboard bench with a behavioural write side and storage array.
module tb_sync_fifo_read_port;
  localparam int depth = 4;
  localparam int pw    = 3;
  logic          clk = 0;
  logic          rst_n = 0;
  logic [pw-1:0] w_ptr = '0;
  logic [pw-1:0] r_ptr;
  logic [pw-2:0] raddr;
  logic [31:0]   rdata;
  logic          flush = 0;
  logic          deq_val;
  logic          deq_rdy = 0;
  logic [31:0]   deq_msg;
  logic          empty;
  logic [31:0]   mem [depth];
  logic [31:0]   q [$];
  int            n_tests = 0;
  int            n_fail = 0;
`ifdef SYNC_FIFO_READ_PORT_COUNT_EN
  logic [pw-1:0] count;
`endif
  sync_fifo_read_port #(.depth(depth), .ptr_width(pw), .bit_width(32)) dut (
    .clk(clk), .rst_n(rst_n), .w_ptr(w_ptr), .r_ptr(r_ptr), .raddr(raddr), .rdata(rdata),
    .flush(flush), .deq_val(deq_val), .deq_rdy(deq_rdy), .deq_msg(deq_msg), .empty(empty)
`ifdef SYNC_FIFO_READ_PORT_COUNT_EN
    , .count(count)
`endif
  );
  always #5 clk = ~clk;
  assign rdata = mem[raddr];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [31:0] d);
    mem[w_ptr[pw-2:0]] = d;
    w_ptr = w_ptr + 1'b1;
    q.push_back(d);
  endtask
  task automatic do_reset;
    rst_n = 0;
    w_ptr = '0;
    q.delete();
    tick;
    tick;
    rst_n = 1;
  endtask
  task automatic drain(input string tag);
    deq_rdy = 1;
    for (int i = 0; i < 40 && q.size() != 0; i++) tick;
    tick;
    chk(tag, 64'(q.size()), 0);
  endtask
  always @(negedge clk)
    if (rst_n && !flush && deq_val && deq_rdy) begin
      if (q.size() == 0) chk("spurious_word", {32'h0, deq_msg}, 64'hdead_0000_0000_0000);
      else chk("data", {32'h0, deq_msg}, {32'h0, q.pop_front()});
    end
  initial begin
    for (int i = 0; i < depth; i++) mem[i] = '0;
    do_reset;
    chk("rst_r_ptr", 64'(r_ptr), 0);
    chk("rst_deq_val", 64'(deq_val), 0);
    chk("rst_empty", 64'(empty), 1);
    chk("rst_deq_msg", 64'(deq_msg), 0);
`ifdef SYNC_FIFO_READ_PORT_COUNT_EN
    chk("rst_count", 64'(count), 0);
`endif
    deq_rdy = 1;
    push(32'hA5A5_0001);
    chk("single_not_yet", 64'(deq_val), 0);
    tick;
    chk("single_val", 64'(deq_val), 1);
    chk("single_msg", 64'(deq_msg), 64'hA5A5_0001);
    chk("single_r_ptr", 64'(r_ptr), 1);
    chk("single_empty", 64'(empty), 1);
    tick;
    tick;
    chk("single_drain", 64'(q.size()), 0);
    chk("single_idle", 64'(deq_val), 0);
    do_reset;
    deq_rdy = 0;
    for (int i = 0; i < 4; i++) begin
      push(32'hB000_0000 + 32'(i));
      if (i < 3) tick;
    end
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("bp_hold_msg", 64'(deq_msg), 64'hB000_0000);
    end
    chk("bp_val", 64'(deq_val), 1);
    chk("bp_r_ptr", 64'(r_ptr), 1);
    chk("bp_empty", 64'(empty), 0);
`ifdef SYNC_FIFO_READ_PORT_COUNT_EN
    chk("bp_count", 64'(count), 4);
`endif
    drain("bp_drain");
    do_reset;
    deq_rdy = 1;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) chk("stream_val", 64'(deq_val), 1);
      push(32'hC000_0000 + 32'(i * 7));
      tick;
    end
    drain("stream_drain");
    chk("stream_r_ptr", 64'(r_ptr), 4);
    chk("stream_empty", 64'(empty), 1);
    do_reset;
    deq_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      push(32'hD000_0000 + 32'(i));
      tick;
    end
    tick;
    chk("pre_flush_r_ptr", 64'(r_ptr), 1);
    chk("pre_flush_val", 64'(deq_val), 1);
    flush = 1;
    q.delete();
    tick;
    flush = 0;
    chk("flush_r_ptr", 64'(r_ptr), 3);
    chk("flush_val", 64'(deq_val), 0);
    chk("flush_empty", 64'(empty), 1);
    deq_rdy = 1;
    tick;
    chk("post_flush_val", 64'(deq_val), 0);
    do_reset;
    deq_rdy = 0;
    push(32'hE000_0001);
    tick;
    push(32'hE000_0002);
    tick;
    chk("mid_pre_val", 64'(deq_val), 1);
    rst_n = 0;
    w_ptr = '0;
    q.delete();
    tick;
    chk("mid_rst_val", 64'(deq_val), 0);
    chk("mid_rst_r_ptr", 64'(r_ptr), 0);
    chk("mid_rst_msg", 64'(deq_msg), 0);
    chk("mid_rst_empty", 64'(empty), 1);
    rst_n = 1;
    deq_rdy = 1;
    tick;
    tick;
    chk("mid_rst_quiet", 64'(deq_val), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sync_fifo_read_port.md
SYNC_FIFO_READ_PORT -- requirements
Module: sync_fifo_read_port

Interface
REQ-001 SHALL have parameter depth, default 4: FIFO entry count; power of two, >= 2.
REQ-002 SHALL have parameter ptr_width, default $clog2(depth)+1: pointer width, including the wrap bit.
REQ-003 SHALL have parameter bit_width, default 32: data word width.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on posedge.
REQ-005 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port w_ptr, input, ptr_width: write pointer from the write-side block.
REQ-007 SHALL have port r_ptr, output, ptr_width: read pointer to the write side, used for full detection.
REQ-008 SHALL have port raddr, output, ptr_width-1: storage read address, equal to r_ptr[ptr_width-2:0].
REQ-009 SHALL have port rdata, input, bit_width: storage word at raddr, read combinationally.
REQ-010 SHALL have port flush, input, 1: discards all stored and staged data.
REQ-011 SHALL have port deq_val, output, 1: the output register holds a valid word.
REQ-012 SHALL have port deq_rdy, input, 1: the consumer accepts the word.
REQ-013 SHALL have port deq_msg, output, bit_width: output register data.
REQ-014 SHALL have port empty, output, 1: storage empty, i.e. r_ptr == w_ptr over all ptr_width bits.

Function
REQ-015 SHALL compute empty combinationally as full-width equality of r_ptr and w_ptr.
REQ-016 SHALL implement a two-state output FSM: IDLE (deq_val=0) and HOLD (deq_val=1).
REQ-017 SHALL define load = ~empty & (~deq_val | deq_rdy) & ~flush.
REQ-018 On load, SHALL capture rdata into deq_msg, increment r_ptr by 1 (modulo 2^ptr_width, the wrap bit toggling naturally), and enter or stay in HOLD.
REQ-019 In HOLD with deq_rdy=1 and load=0, SHALL go to IDLE; deq_msg is don't-care.
REQ-020 In HOLD with deq_rdy=0, SHALL keep deq_msg and r_ptr stable.
REQ-021 In HOLD with deq_rdy=1 and ~empty, SHALL accept and refill in the same cycle, sustaining 1 word/cycle.
REQ-022 Latency: when w_ptr advances from empty at edge N, deq_val SHALL assert after edge N+1.
REQ-023 SHALL increment r_ptr at most once per cycle and never while empty.
REQ-024 flush=1 SHALL set r_ptr <= w_ptr and FSM <= IDLE at the next edge; it overrides load and deq_rdy.
REQ-025 Wrap-around: after 2*depth loads, r_ptr SHALL return to its initial value, with no lost or duplicated word.
REQ-026 deq_msg SHALL be driven only from the output register, with no combinational path from rdata.

Reset
REQ-027 With rst_n=0 at a posedge, SHALL set r_ptr=0, FSM=IDLE (deq_val=0) and deq_msg=0; this priority is above flush and load.
REQ-028 Reset mid-operation SHALL discard the staged word; the write side is reset in the same cycle, so empty=1 after reset.

Configuration
REQ-029 Macro SYNC_FIFO_READ_PORT_COUNT_EN defined SHALL add output count[ptr_width-1:0] = (w_ptr - r_ptr) + deq_val, the total words held including staged, range 0..depth+1.
REQ-030 Without SYNC_FIFO_READ_PORT_COUNT_EN, the count port and its logic SHALL NOT exist; all other behaviour is identical.

Verification
REQ-031 Reset: rst_n=0 for 2 cycles with w_ptr=0 -> r_ptr=0, deq_val=0, empty=1, deq_msg=0.
REQ-032 Single word: w_ptr 0->1, rdata=0xA5A5_0001, deq_rdy=1 -> deq_val=1 with deq_msg=0xA5A5_0001 one cycle later, r_ptr=1, empty=1.
REQ-033 Backpressure: depth=4, 4 words written, deq_rdy=0 for 5 cycles -> deq_msg held at word0, r_ptr=1, count=4 (COUNT_EN).
REQ-034 Streaming wrap: depth=4, 20 consecutive words with deq_rdy=1 -> 20 in-order outputs, 1/cycle after the first; r_ptr=20 mod 8=4.
REQ-035 Flush: w_ptr=3, r_ptr=1, HOLD, flush=1 for one cycle -> r_ptr=3, deq_val=0, empty=1 next cycle.
REQ-036 Reset mid-stream: rst_n=0 while deq_val=1 and deq_rdy=0 -> deq_val=0 and r_ptr=0 next cycle; no word emitted.
